// File: rtl/rr_arbiter_16.sv
// 16-requester round-robin arbiter with registered one-hot grant and index.
// Define ARB_TIMEOUT_EN to build the MAX_HOLD grant-revocation counter.
module rr_arbiter_16 #(
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_id,
    output logic        gnt_valid,
    output logic        timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [3:0]  ptr;
    logic [3:0]  ptr_n;
    logic [3:0]  owner;
    logic [3:0]  owner_n;
    logic [3:0]  id_n;
    logic [15:0] gnt_n;
    logic [3:0]  win;
    logic        found;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter_16: MAX_HOLD must be in 2..255");
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic [7:0] hold_n;
    logic       timeout_n;
`endif

    // First set request at or after ptr, wrapping modulo 16.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!found && req[4'(ptr + 4'(i))]) begin
                found = 1'b1;
                win   = 4'(ptr + 4'(i));
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        gnt_n   = gnt;
        id_n    = gnt_id;
`ifdef ARB_TIMEOUT_EN
        hold_n    = hold_cnt;
        timeout_n = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                gnt_n = '0;
                id_n  = '0;
                if (found) begin
                    state_n = GRANT;
                    owner_n = win;
                    ptr_n   = win + 4'd1;
                    gnt_n   = 16'h0001 << win;
                    id_n    = win;
`ifdef ARB_TIMEOUT_EN
                    hold_n  = '0;
`endif
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    id_n    = '0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt == 8'(MAX_HOLD - 1)) begin
                    state_n   = IDLE;
                    gnt_n     = '0;
                    id_n      = '0;
                    timeout_n = 1'b1;
                end else begin
                    hold_n = hold_cnt + 8'd1;
                end
`endif
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                id_n    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            owner  <= '0;
            gnt    <= '0;
            gnt_id <= '0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            owner  <= owner_n;
            gnt    <= gnt_n;
            gnt_id <= id_n;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= hold_n;
            timeout  <= timeout_n;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign gnt_valid = (state == GRANT);

endmodule

// File: doc/rr_arbiter_16.md
# rr_arbiter_16

Round-robin arbiter that shares one 16-input encode resource, or any single-owner downstream resource, among 16 requesters. It registers a one-hot grant together with its 4-bit encoded index, so the grant bus feeds the 16-to-4 encode path directly. A grant is held until the owner releases its request. With the hold-limit feature compiled in, a grant is forcibly revoked after a bounded number of cycles.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles when `ARB_TIMEOUT_EN` is defined; legal range 2..255; ignored otherwise.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous reset, active-high.
- `req` input 16: request lines, bit k = requester k; level-sensitive.
- `gnt` output 16: registered one-hot grant; all-zero when nothing is granted.
- `gnt_id` output 4: binary index of the set `gnt` bit; 0 when `gnt_valid`=0.
- `gnt_valid` output 1: high while any grant is active (equals |`gnt`).
- `timeout` output 1: one-cycle pulse when a grant is revoked by the hold limit; tied 0 without `ARB_TIMEOUT_EN`.

## Operation
- Clock and reset: one clock (`clk`); reset is synchronous and active-high (`rst`).
- States:
  - IDLE: no grant.
  - GRANT: one owner.
- Registers:
  - `ptr[3:0]`: round-robin start index.
  - `owner[3:0]`: index of the current owner.
  - `hold_cnt[7:0]`: present only with the macro.
- IDLE → GRANT: at an edge where `req` != 0.
  - Winner = first set `req` bit searching `ptr`, `ptr`+1, …, 15, 0, …, `ptr`-1 (mod 16).
  - `gnt` = 1<<winner, `gnt_id` = winner, `gnt_valid` = 1.
  - `ptr` ← winner+1 mod 16, so 15 wraps to 0.
- IDLE → IDLE: when `req` == 0; outputs remain 0.
- GRANT → IDLE (release): at an edge where `req[owner]` == 0; `gnt`, `gnt_id` and `gnt_valid` clear at that edge.
- GRANT → GRANT otherwise. Other requests are ignored while a grant is held; there is no preemption.
- Every release passes through one IDLE cycle before re-arbitration, including a release immediately followed by a new request.
- Requests from non-owners may change freely at any time. Only `req[owner]` is examined in GRANT.
- `ptr` updates only on a new grant, never on release or timeout.
- Reset:
  - State ← IDLE, `ptr` ← 0, `owner` ← 0, `hold_cnt` ← 0.
  - `gnt` = 0, `gnt_id` = 0, `gnt_valid` = 0, `timeout` = 0.
  - `rst` dominates all other inputs, including mid-grant; the grant drops at the reset edge.

## Timing
- Grant latency: 1 edge. `req` set before edge N → `gnt` visible after edge N.
- Release latency: 1 edge. `req[owner]` low before edge M → `gnt` = 0 after edge M; earliest next grant after edge M+1.
- All outputs are registered; there are no combinational paths from `req` to the outputs.
- Back-to-back single-cycle owners under full load: grant duty is 1 cycle on, 1 cycle off.
- `gnt_id` and `gnt` change on the same edge and are always consistent.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - `hold_cnt` clears on each new grant and increments every GRANT cycle.
  - When `gnt` has been high for `MAX_HOLD` cycles, the next edge forces GRANT → IDLE, clears `gnt`, and sets `timeout` for exactly that one IDLE cycle.
  - Release and timeout on the same edge count as a release: `timeout` stays 0.
  - A revoked owner that keeps requesting competes normally. `ptr` has already moved past it, so it is served last.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is built and grants are unbounded.
  - `timeout` is constant 0.

## Test plan
- Reset: `rst`=1 for 2 cycles with `req`=16'hFFFF → `gnt`=16'h0000, `gnt_id`=0, `gnt_valid`=0, `timeout`=0 throughout.
- Single request: `req`=16'h0020 → after one edge `gnt`=16'h0020, `gnt_id`=5. Hold 3 cycles, then drop `req` → `gnt`=0 after the next edge.
- Full rotation: `req`=16'hFFFF, each owner drops its bit for one cycle after being granted → `gnt_id` sequence 0,1,2,…,15,0 with one IDLE cycle between grants (checks wrap).
- Pointer fairness: after id 5 is granted and released, apply `req`=16'h0011 → grant goes to id 0, not id 4 (search starts at 6 and wraps). Next, `req`=16'h0010 → id 4.
- Hold limit with macro, `MAX_HOLD`=4, `req`=16'h0008 held constantly:
  - `gnt`=16'h0008 for exactly 4 cycles.
  - Then one cycle with `gnt`=0 and `timeout`=1.
  - Then regranted to id 3.
- Hold limit without macro, same stimulus: `gnt` stays 16'h0008 for 20 cycles and `timeout`=0.
- Reset mid-grant: owner id 7 active, `rst` pulsed 1 cycle → `gnt`=0 after that edge. Then `req`=16'h8001 → `gnt_id`=0 (`ptr` reset to 0).
